dirty_mem_dump: RTL and testbench

Debug-side consumer of the data-memory dirty-bit controller: on request, scans every data-memory word, skips clean entries, and streams each dirty word to the UART transmitter as a 5-byte frame, then ends with a terminator byte. Sits between the Memory stage (dirty-bit array plus data memory read port) and the debug unit's UART TX. The pipeline is halted by the debug unit for the whole dump; memory writes during a dump are outside this block's contract.

---
 rtl/dirty_mem_dump.sv | 129 ++++++++++++
 tb/tb_dirty_mem_dump.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dirty_mem_dump.sv
// dirty_mem_dump: scans every data-memory word after a start request and
// streams each dirty word to the UART TX as a 5-byte frame
// {addr, data[31:24], data[23:16], data[15:8], data[7:0]}, then sends 8'hFF.
// The frame layout is fixed to 7-bit addresses and 32-bit data words.
module dirty_mem_dump #(
  parameter int N_ELEMENTS = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_addr,
  input  logic                  i_bit_sucio,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ELEMENTS - 1);
  localparam logic [7:0]            TERM_BYTE = 8'hFF;

  typedef enum logic [3:0] {
    IDLE, CHECK, READ, SEND, WAIT, NEXT, TERM, TERM_WAIT, DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [39:0]           frame_reg, frame_next;
  logic [2:0]            idx_reg, idx_next;
  logic [7:0]            count_reg, count_next;

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      frame_reg <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      frame_reg <= frame_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic and state-decoded outputs (tx strobe drops with state on reset).
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    frame_next = frame_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    o_tx_start = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        o_busy    = 1'b0;
        addr_next = '0;
        if (i_start) begin
          state_next = CHECK;
          count_next = 8'd0;
        end
      end
      CHECK: state_next = i_bit_sucio ? READ : NEXT;
      READ: begin
        // Data memory has a registered read; the word is valid one cycle after CHECK.
        frame_next = {1'b0, 7'(addr_reg), i_mem_data[31:0]};
        idx_next   = 3'd0;
        state_next = SEND;
      end
      SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = frame_reg[39:32];
        state_next = WAIT;
      end
      WAIT: begin
        o_tx_data = frame_reg[39:32];
        if (i_tx_done) begin
          frame_next = {frame_reg[31:0], 8'h00};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd4) begin
            state_next = NEXT;
            count_next = count_reg + 8'd1;
          end else begin
            state_next = SEND;
          end
        end
      end
      NEXT: begin
        // Stop at the last word instead of wrapping back to address 0.
        if (addr_reg == LAST_ADDR) begin
          state_next = TERM;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = CHECK;
        end
      end
      TERM: begin
        o_tx_start = 1'b1;
        o_tx_data  = TERM_BYTE;
        state_next = TERM_WAIT;
      end
      TERM_WAIT: begin
        o_tx_data = TERM_BYTE;
        if (i_tx_done) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        addr_next  = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_addr  = addr_reg;
  assign o_count = count_reg;

endmodule

// File: tb/tb_dirty_mem_dump.sv
// tb_dirty_mem_dump: scoreboard bench. Expected UART bytes are queued when a
// dirty/memory pattern is loaded and popped as the DUT strobes o_tx_start.
module tb_dirty_mem_dump;

  localparam int N = 128;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_bit_sucio;
  logic [31:0] i_mem_data;
  logic        i_tx_done;
  logic [6:0]  o_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_count;

  logic        dirty [N];
  logic [31:0] mem   [N];
  logic [7:0]  exp_q [$];

  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  bit   spur_en   = 1'b0;
  int   uart_cnt  = 0;
  int   n_starts  = 0;
  int   done_seen = 0;
  bit   wrapped   = 1'b0;
  int   last_addr = 0;
  int   n_vectors = 0;
  int   n_miscompares = 0;

  dirty_mem_dump #(.N_ELEMENTS(128), .ADDR_WIDTH(7), .DATA_WIDTH(32)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .o_addr     (o_addr),
    .i_bit_sucio(i_bit_sucio),
    .i_mem_data (i_mem_data),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count)
  );

  always #5 i_clock = ~i_clock;

  // Memory-stage model: combinational dirty bit, registered data read.
  assign i_bit_sucio = dirty[o_addr];
  assign i_tx_done   = uart_done | spur_done;
  always @(posedge i_clock) i_mem_data <= mem[o_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // UART model (done 3 cycles after start), scoreboard pop, optional spurious done.
  always @(negedge i_clock) begin
    uart_done = 1'b0;
    spur_done = 1'b0;
    if (!i_reset) begin
      uart_cnt = 0;
    end else begin
      if (o_busy) begin
        if (int'(o_addr) < last_addr) wrapped = 1'b1;
        last_addr = int'(o_addr);
      end
      if (o_done) done_seen++;
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_done = 1'b1;
      end
      if (o_tx_start) begin
        n_starts++;
        check_val("tx_start_uart_idle", {31'd0, (uart_cnt == 0 && !uart_done)}, 32'd1);
        if (exp_q.size() == 0) begin
          check_val("tx_byte_unexpected", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
        end else begin
          check_val("tx_byte", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
        end
        uart_cnt = 3;
      end else if (spur_en && o_busy && uart_cnt == 0 && !uart_done &&
                   $urandom_range(0, 2) == 0) begin
        spur_done = 1'b1;
      end
    end
  end

  task automatic build_expected();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (dirty[k]) begin
        exp_q.push_back({1'b0, 7'(k)});
        exp_q.push_back(mem[k][31:24]);
        exp_q.push_back(mem[k][23:16]);
        exp_q.push_back(mem[k][15:8]);
        exp_q.push_back(mem[k][7:0]);
      end
    end
    exp_q.push_back(8'hFF);
  endtask

  task automatic clear_pattern();
    for (int k = 0; k < N; k++) begin
      dirty[k] = 1'b0;
      mem[k]   = 32'h0;
    end
  endtask

  // One dump: start, run until o_done (bounded), then check results.
  task automatic run_dump(input string tag, input int exp_cnt, input int exp_cycles, input bit noisy);
    int cycles;
    build_expected();
    n_starts  = 0;
    done_seen = 0;
    wrapped   = 1'b0;
    last_addr = 0;
    cycles    = 0;
    @(negedge i_clock);
    i_start = 1'b1;
    spur_en = noisy;
    forever begin
      @(posedge i_clock);
      cycles++;
      @(negedge i_clock);
      if (o_done) begin
        i_start = 1'b0;
        break;
      end
      i_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cycles > 20000) begin
        check_val({tag, "_timeout"}, 32'(cycles), 32'(exp_cycles));
        i_start = 1'b0;
        break;
      end
    end
    spur_en = 1'b0;
    if (exp_cycles > 0) check_val({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
    @(negedge i_clock);
    check_val({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_count"}, {24'd0, o_count}, 32'(exp_cnt));
    check_val({tag, "_tx_starts"}, 32'(n_starts), 32'(5 * exp_cnt + 1));
    check_val({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
    check_val({tag, "_addr_wrap"}, {31'd0, wrapped}, 32'd0);
    check_val({tag, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
    check_val({tag, "_idle_addr"}, {25'd0, o_addr}, 32'd0);
    $display("dump %s: %0d cycles, %0d tx starts, count %0d", tag, cycles, n_starts, o_count);
  endtask

  initial begin
    int guard;
    clear_pattern();
    #1;
    check_val("rst_addr", {25'd0, o_addr}, 32'd0);
    check_val("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check_val("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    check_val("rst_busy", {31'd0, o_busy}, 32'd0);
    check_val("rst_done", {31'd0, o_done}, 32'd0);
    check_val("rst_count", {24'd0, o_count}, 32'd0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    // All clean: only the terminator; 256 scan + TERM + 3 wait + DONE.
    run_dump("all_clean", 0, 261, 1'b0);

    // Addresses 0..5 dirty.
    clear_pattern();
    for (int k = 0; k < 6; k++) begin
      dirty[k] = 1'b1;
      mem[k]   = 32'hA5A5_0000 + 32'(k);
    end
    run_dump("first_six", 6, 0, 1'b0);

    // Only the last address dirty.
    clear_pattern();
    dirty[127] = 1'b1;
    mem[127]   = 32'hDEAD_BEEF;
    run_dump("last_only", 1, 0, 1'b0);

    // Scattered pattern with repeated start requests and spurious tx_done.
    clear_pattern();
    for (int k = 0; k < 6; k++) begin
      dirty[k] = 1'b1;
      mem[k]   = 32'hA5A5_0000 + 32'(k);
    end
    dirty[40] = 1'b1; mem[40] = 32'h1234_5678;
    dirty[99] = 1'b1; mem[99] = 32'h0BAD_F00D;
    run_dump("noisy", 8, 0, 1'b1);

    // Reset during WAIT of address 3, then a complete rerun.
    clear_pattern();
    for (int k = 0; k < 6; k++) begin
      dirty[k] = 1'b1;
      mem[k]   = 32'hA5A5_0000 + 32'(k);
    end
    build_expected();
    @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    guard = 0;
    while (!(o_tx_start && o_addr == 7'd3) && guard < 2000) begin
      @(negedge i_clock);
      guard++;
    end
    check_val("reach_addr3_send", 32'(guard < 2000), 32'd1);
    @(posedge i_clock);
    #2;
    check_val("pre_reset_count", {24'd0, o_count}, 32'd3);
    i_reset = 1'b0;
    #1;
    check_val("async_tx_start", {31'd0, o_tx_start}, 32'd0);
    check_val("async_busy", {31'd0, o_busy}, 32'd0);
    check_val("async_count", {24'd0, o_count}, 32'd0);
    check_val("async_addr", {25'd0, o_addr}, 32'd0);
    repeat (3) @(negedge i_clock);
    exp_q.delete();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    run_dump("after_reset", 6, 0, 1'b0);

    // Every word dirty: 641 bytes, count reaches 128.
    for (int k = 0; k < N; k++) begin
      dirty[k] = 1'b1;
      mem[k]   = $urandom;
    end
    run_dump("all_dirty", 128, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
